// File: rtl/div23_rem_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : div23_rem_stage
// Purpose  : Registered stage behind the combinational 16-bit divide-by-23
//            quotient block. It captures each dividend X with its quotient Q,
//            forms R = X - 23*Q and flags an inconsistent Q. The resulting
//            {Q, R, err} beat leaves through a 2-entry skid buffer, which keeps
//            out_ready off every timing path back into the divider.
// Ports    : clk, rst_n (async, active low), clr (sync flush)
//            in_valid / in_ready / in_x / in_q          - upstream beat
//            out_valid / out_ready / out_q / out_r / out_err - downstream beat
//            err_cnt                                    - saturating error count
// Options  : DIV23_ERR_CNT_EN - when defined, err_cnt counts accepted beats
//            with err=1 and saturates at 255. When undefined, err_cnt is 0.
// Revision : 1.0 - initial release
// ============================================================================
module div23_rem_stage #(
    parameter int XW      = 16,
    parameter int QW      = 12,
    parameter int RW      = 5,
    parameter int DIVISOR = 23
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [XW-1:0] in_x,
    input  logic [QW-1:0] in_q,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [QW-1:0] out_q,
    output logic [RW-1:0] out_r,
    output logic          out_err,
    output logic [7:0]    err_cnt
);

    // DW holds the signed difference; PW holds DIVISOR*Q for any QW-bit Q.
    localparam int DW = XW + 2;
    localparam int PW = XW + 1;

    // ------------------------------------------------------------------
    // Remainder and consistency check on the incoming beat
    // ------------------------------------------------------------------
    logic [PW-1:0]        w_prod;
    logic signed [DW-1:0] w_diff;
    logic                 w_err;
    logic [RW-1:0]        w_r;

    assign w_prod = PW'(DIVISOR) * PW'(in_q);
    assign w_diff = signed'({2'b00, in_x}) - signed'({1'b0, w_prod});
    // Negative difference (Q too large) or difference >= DIVISOR (Q too small).
    assign w_err  = w_diff[DW-1] | (w_diff[DW-2:0] >= (DW-1)'(DIVISOR));
    // Raw low bits are passed along even for a bad quotient.
    assign w_r    = w_diff[RW-1:0];

    // ------------------------------------------------------------------
    // Skid buffer state
    // ------------------------------------------------------------------
    logic          r_main_valid, r_skid_valid, r_ready;
    logic [QW-1:0] r_main_q, r_skid_q;
    logic [RW-1:0] r_main_r, r_skid_r;
    logic          r_main_err, r_skid_err;

    logic          w_main_valid_nxt, w_skid_valid_nxt;
    logic [QW-1:0] w_main_q_nxt, w_skid_q_nxt;
    logic [RW-1:0] w_main_r_nxt, w_skid_r_nxt;
    logic          w_main_err_nxt, w_skid_err_nxt;
    logic          w_accept, w_emit;

    // r_ready mirrors "skid empty"; clr only masks it for its own cycle.
    assign in_ready  = r_ready & ~clr;
    assign w_accept  = in_valid & in_ready;
    assign w_emit    = r_main_valid & out_ready;

    assign out_valid = r_main_valid;
    assign out_q     = r_main_q;
    assign out_r     = r_main_r;
    assign out_err   = r_main_err;

    always_comb begin
        w_main_valid_nxt = r_main_valid;
        w_main_q_nxt     = r_main_q;
        w_main_r_nxt     = r_main_r;
        w_main_err_nxt   = r_main_err;
        w_skid_valid_nxt = r_skid_valid;
        w_skid_q_nxt     = r_skid_q;
        w_skid_r_nxt     = r_skid_r;
        w_skid_err_nxt   = r_skid_err;

        if (clr) begin
            w_main_valid_nxt = 1'b0;
            w_skid_valid_nxt = 1'b0;
        end else if (!r_main_valid || w_emit) begin
            // Main frees up. An occupied skid always holds the older beat,
            // and no accept can coincide with it because in_ready is low.
            if (r_skid_valid) begin
                w_main_valid_nxt = 1'b1;
                w_main_q_nxt     = r_skid_q;
                w_main_r_nxt     = r_skid_r;
                w_main_err_nxt   = r_skid_err;
                w_skid_valid_nxt = 1'b0;
            end else if (w_accept) begin
                w_main_valid_nxt = 1'b1;
                w_main_q_nxt     = in_q;
                w_main_r_nxt     = w_r;
                w_main_err_nxt   = w_err;
            end else begin
                w_main_valid_nxt = 1'b0;
            end
        end else if (w_accept) begin
            // Main is stalled: park the new beat behind it.
            w_skid_valid_nxt = 1'b1;
            w_skid_q_nxt     = in_q;
            w_skid_r_nxt     = w_r;
            w_skid_err_nxt   = w_err;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_valid <= 1'b0;
            r_main_q     <= '0;
            r_main_r     <= '0;
            r_main_err   <= 1'b0;
            r_skid_valid <= 1'b0;
            r_skid_q     <= '0;
            r_skid_r     <= '0;
            r_skid_err   <= 1'b0;
            r_ready      <= 1'b0;
        end else begin
            r_main_valid <= w_main_valid_nxt;
            r_main_q     <= w_main_q_nxt;
            r_main_r     <= w_main_r_nxt;
            r_main_err   <= w_main_err_nxt;
            r_skid_valid <= w_skid_valid_nxt;
            r_skid_q     <= w_skid_q_nxt;
            r_skid_r     <= w_skid_r_nxt;
            r_skid_err   <= w_skid_err_nxt;
            r_ready      <= ~w_skid_valid_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Error counter (survives clr, cleared only by rst_n)
    // ------------------------------------------------------------------
`ifdef DIV23_ERR_CNT_EN
    logic [7:0] r_err_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= 8'd0;
        end else if (w_accept && w_err && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign err_cnt = r_err_cnt;
`else
    assign err_cnt = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_div23_rem_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_div23_rem_stage
// Purpose  : Self-checking bench for div23_rem_stage. A queue model predicts
//            the buffered beats from plain arithmetic; a compare process
//            checks every cycle; directed sequences add hand-computed values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_div23_rem_stage;

    logic        clk = 1'b0;
    logic        rst_n, clr, in_valid, in_ready, out_valid, out_ready, out_err;
    logic [15:0] in_x;
    logic [11:0] in_q, out_q;
    logic [4:0]  out_r;
    logic [7:0]  err_cnt;

    div23_rem_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_q      (in_q),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_q     (out_q),
        .out_r     (out_r),
        .out_err   (out_err),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [11:0] q;
        logic [4:0]  r;
        logic        e;
    } beat_t;

    beat_t mq[$];
    int    mcnt   = 0;
    int    checks = 0;
    int    errors = 0;
    logic  seen_edge;

    int sx[8], sq[8], eq[8], er[8], ee[8];

`ifdef DIV23_ERR_CNT_EN
    localparam int CNT_AFTER_CLR = 4;
    localparam int CNT_SAT       = 255;
`else
    localparam int CNT_AFTER_CLR = 0;
    localparam int CNT_SAT       = 0;
`endif

    // Reference: remainder is plain integer X - 23*Q, low 5 bits kept raw.
    function automatic beat_t model(input int x, input int q);
        beat_t b;
        int    d;
        d   = x - 23 * q;
        b.q = q[11:0];
        b.r = 5'(d & 31);
        b.e = (d < 0) || (d >= 23);
        return b;
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // in_ready is only expected after the first clock edge following reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) seen_edge <= 1'b0;
        else        seen_edge <= 1'b1;
    end

    // Per-cycle compare against the queue model, mid-cycle.
    always @(negedge clk) begin : mon
        beat_t f;
        logic  exp_ready;
        if (rst_n) begin
            exp_ready = seen_edge && (mq.size() < 2) && !clr;
            chk("in_ready", int'(in_ready), int'(exp_ready));
            chk("out_valid", int'(out_valid), int'(mq.size() != 0));
            if (mq.size() != 0) begin
                f = mq[0];
                chk("out_q", int'(out_q), int'(f.q));
                chk("out_r", int'(out_r), int'(f.r));
                chk("out_err", int'(out_err), int'(f.e));
            end
            chk("err_cnt", int'(err_cnt), mcnt);
            if (clr) begin
                mq.delete();
            end else begin
                if (out_valid && out_ready && mq.size() != 0) void'(mq.pop_front());
                if (in_valid && in_ready) begin
                    f = model(int'(in_x), int'(in_q));
                    mq.push_back(f);
`ifdef DIV23_ERR_CNT_EN
                    if (f.e && mcnt < 255) mcnt++;
`endif
                end
            end
        end
    end

    task automatic lit(input int k, input string tag);
        chk({tag, "_valid"}, int'(out_valid), 1);
        chk({tag, "_q"}, int'(out_q), eq[k]);
        chk({tag, "_r"}, int'(out_r), er[k]);
        chk({tag, "_err"}, int'(out_err), ee[k]);
    endtask

    // Back-to-back beats with out_ready=1; each checked one cycle after accept.
    task automatic stream(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_x     = 16'(sx[i]);
            in_q     = 12'(sq[i]);
            @(negedge clk);
            if (i > 0) lit(i - 1, tag);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        lit(n - 1, tag);
    endtask

    task automatic drive(input int x, input int q);
        in_valid = 1'b1;
        in_x     = 16'(x);
        in_q     = 12'(q);
    endtask

    task automatic tick;
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: timeout expired, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0;
        in_x = '0; in_q = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_q", int'(out_q), 0);
        chk("rst_r", int'(out_r), 0);
        chk("rst_err", int'(out_err), 0);
        chk("rst_cnt", int'(err_cnt), 0);
        rst_n = 1'b1;
        tick();

        // Correct quotients streaming
        sx[0] = 0;     sq[0] = 0;    eq[0] = 0;    er[0] = 0;  ee[0] = 0;
        sx[1] = 45;    sq[1] = 1;    eq[1] = 1;    er[1] = 22; ee[1] = 0;
        sx[2] = 46;    sq[2] = 2;    eq[2] = 2;    er[2] = 0;  ee[2] = 0;
        sx[3] = 65535; sq[3] = 2849; eq[3] = 2849; er[3] = 8;  ee[3] = 0;
        stream(4, "stream");
        tick();

        // Injected bad quotients
        sx[0] = 100; sq[0] = 5; eq[0] = 5; er[0] = 17; ee[0] = 1;
        sx[1] = 100; sq[1] = 3; eq[1] = 3; er[1] = 31; ee[1] = 1;
        sx[2] = 100; sq[2] = 4; eq[2] = 4; er[2] = 8;  ee[2] = 0;
        stream(3, "badq");
        tick();

        // Backpressure: three beats offered with out_ready=0
        out_ready = 1'b0;
        drive(35, 1);
        @(negedge clk); chk("bp_rdy1", int'(in_ready), 1);
        tick(); drive(60, 2);
        @(negedge clk); chk("bp_rdy2", int'(in_ready), 1);
        tick(); drive(80, 3);
        @(negedge clk);
        chk("bp_stall", int'(in_ready), 0);
        chk("bp_hold_q", int'(out_q), 1);
        chk("bp_hold_r", int'(out_r), 12);
        repeat (2) begin
            tick();
            @(negedge clk); chk("bp_stall2", int'(in_ready), 0);
        end
        tick(); out_ready = 1'b1;
        tick();
        @(negedge clk);
        chk("bp_second_q", int'(out_q), 2);
        chk("bp_second_r", int'(out_r), 14);
        chk("bp_rdy_back", int'(in_ready), 1);
        tick(); in_valid = 1'b0;
        @(negedge clk);
        chk("bp_third_q", int'(out_q), 3);
        chk("bp_third_r", int'(out_r), 11);
        repeat (2) tick();

        // clr with both entries full and a beat offered
        out_ready = 1'b0;
        drive(100, 5); tick();
        drive(100, 3); tick();
        clr = 1'b1; drive(100, 6);
        @(negedge clk); chk("clr_rdy", int'(in_ready), 0);
        tick(); clr = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("clr_valid", int'(out_valid), 0);
        chk("clr_cnt", int'(err_cnt), CNT_AFTER_CLR);
        tick(); out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk); chk("clr_no_emit", int'(out_valid), 0);
            tick();
        end

        // Asynchronous reset mid-stream
        drive(46, 2); tick();
        drive(45, 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", int'(out_valid), 0);
        chk("arst_q", int'(out_q), 0);
        chk("arst_r", int'(out_r), 0);
        chk("arst_err", int'(out_err), 0);
        chk("arst_cnt", int'(err_cnt), 0);
        mq.delete();
        mcnt = 0;
        in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        drive(46, 2); tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("arst_lat_valid", int'(out_valid), 1);
        chk("arst_lat_q", int'(out_q), 2);
        chk("arst_lat_r", int'(out_r), 0);
        tick();

        // Long run of bad beats: counter saturation (or stays 0)
        for (int i = 0; i < 300; i++) begin
            drive(100, 5); tick();
        end
        in_valid = 1'b0;
        @(negedge clk); chk("sat_cnt", int'(err_cnt), CNT_SAT);
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(100, 3); tick();
        end
        in_valid = 1'b0;
        @(negedge clk); chk("sat_hold", int'(err_cnt), CNT_SAT);
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
